// File: rtl/wam_bcd_countdown_if.sv
// Control and display bundle between the game controller and the round countdown timer.
// The timer sits on the slave side; the controller and display decoders sit on the master side.
interface wam_bcd_countdown_if;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic       start;
  logic       pause;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       tens_en;
  logic       ones_en;
  logic       running;
  logic       expired;
  logic       done;

  modport master (
    output load, load_tens, load_ones, start, pause,
    input  tens, ones, tens_en, ones_en, running, expired, done
  );

  modport slave (
    input  load, load_tens, load_ones, start, pause,
    output tens, ones, tens_en, ones_en, running, expired, done
  );
endinterface

// File: rtl/wam_bcd_countdown.sv
// Two-digit BCD round timer: divides clock into one-second ticks and counts down to 00.
// Every output is decoded from registered state, so no input reaches an output combinationally.
//
// state   | meaning
// IDLE    | holding a value; load or start accepted
// RUN     | prescaler counting, value decrements on each wrap
// PAUSED  | prescaler and digits frozen until the next pause pulse
// EXPIRED | value is 00; only load leaves this state
module wam_bcd_countdown #(
  parameter int TICK_DIV   = 50000000,
  parameter int START_TENS = 6,
  parameter int START_ONES = 0
) (
  input logic                 clock,
  input logic                 reset,
  wam_bcd_countdown_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      ones_q, ones_d;
  logic            done_q, done_d;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] digit);
    return (digit > 4'd9) ? 4'd9 : digit;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      tens_q  <= 4'(START_TENS);
      ones_q  <= 4'(START_ONES);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          tens_d = clamp_bcd(bus.load_tens);
          ones_d = clamp_bcd(bus.load_ones);
        end else if (bus.start) begin
          if ((tens_q != 4'd0) || (ones_q != 4'd0)) begin
            state_d = RUN;
            presc_d = '0;
          end else begin
            state_d = EXPIRED;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        // A pause edge wins over a coincident tick, leaving the prescaler parked.
        if (bus.pause) begin
          state_d = PAUSED;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end else begin
            ones_d = ones_q - 4'd1;
            if ((tens_q == 4'd0) && (ones_q == 4'd1)) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      PAUSED: begin
        if (bus.pause) begin
          state_d = RUN;
        end
      end
      EXPIRED: begin
        if (bus.load) begin
          tens_d  = clamp_bcd(bus.load_tens);
          ones_d  = clamp_bcd(bus.load_ones);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.tens    = tens_q;
  assign bus.ones    = ones_q;
  assign bus.tens_en = (tens_q != 4'd0);
  assign bus.ones_en = 1'b1;
  assign bus.running = (state_q == RUN);
  assign bus.expired = (state_q == EXPIRED);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_wam_bcd_countdown.sv
// Bench for the round countdown timer: directed scenarios then random control traffic,
// all compared each cycle against a seconds-valued model of the round clock.
module tb_wam_bcd_countdown;

  localparam int TICK_DIV   = 4;
  localparam int START_TENS = 6;
  localparam int START_ONES = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;

  logic clock;
  logic reset;
  wam_bcd_countdown_if bus();

  wam_bcd_countdown #(
    .TICK_DIV   (TICK_DIV),
    .START_TENS (START_TENS),
    .START_ONES (START_ONES)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  int  m_mode;
  int  m_secs;
  int  m_cnt;
  bit  m_done;
  int  m_done_count;

  task automatic check_val(input string tag, input int actual, input int expected);
    n_total++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int clamp9(input int d);
    return (d > 9) ? 9 : d;
  endfunction

  // Round clock model: value held as whole seconds, counted in plain integers.
  task automatic model_step(input bit rst_n, input bit ld, input int lt, input int lo,
                            input bit st, input bit pa);
    m_done = 1'b0;
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_secs = START_TENS * 10 + START_ONES;
      m_cnt  = 0;
      m_done_count = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (ld) begin
            m_secs = clamp9(lt) * 10 + clamp9(lo);
            m_done_count = 0;
          end else if (st) begin
            if (m_secs != 0) begin
              m_mode = M_RUN;
              m_cnt  = 0;
            end else begin
              m_mode = M_EXPIRED;
              m_done = 1'b1;
            end
          end
        end
        M_RUN: begin
          if (pa) m_mode = M_PAUSED;
          else begin
            m_cnt++;
            if (m_cnt == TICK_DIV) begin
              m_cnt  = 0;
              m_secs = m_secs - 1;
              if (m_secs == 0) begin
                m_mode = M_EXPIRED;
                m_done = 1'b1;
              end
            end
          end
        end
        M_PAUSED: if (pa) m_mode = M_RUN;
        default: begin
          if (ld) begin
            m_secs = clamp9(lt) * 10 + clamp9(lo);
            m_mode = M_IDLE;
            m_done_count = 0;
          end
        end
      endcase
      if (m_done) m_done_count++;
    end
  endtask

  task automatic cycle(input bit rst_n, input bit ld, input int lt, input int lo,
                       input bit st, input bit pa);
    reset         = rst_n;
    bus.load      = ld;
    bus.load_tens = 4'(lt);
    bus.load_ones = 4'(lo);
    bus.start     = st;
    bus.pause     = pa;
    @(posedge clock);
    model_step(rst_n, ld, lt, lo, st, pa);
    #1;
    check_val("tens",    int'(bus.tens),    m_secs / 10);
    check_val("ones",    int'(bus.ones),    m_secs % 10);
    check_val("tens_en", int'(bus.tens_en), int'(m_secs >= 10));
    check_val("ones_en", int'(bus.ones_en), 1);
    check_val("running", int'(bus.running), int'(m_mode == M_RUN));
    check_val("expired", int'(bus.expired), int'(m_mode == M_EXPIRED));
    check_val("done",    int'(bus.done),    int'(m_done));
    check_val("done_once", int'(m_done_count <= 1), 1);
    @(negedge clock);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.load = 1'b0; bus.load_tens = '0; bus.load_ones = '0;
    bus.start = 1'b0; bus.pause = 1'b0;
    m_mode = M_IDLE; m_secs = 0; m_cnt = 0; m_done = 0; m_done_count = 0;
    @(negedge clock);

    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 3, 3, 1, 1);
    idle_cycles(2);

    cycle(1, 0, 0, 0, 1, 0);
    idle_cycles(9);

    cycle(1, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 1);
    idle_cycles(3);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 2, 0, 0);
    cycle(1, 0, 0, 0, 1, 0);
    idle_cycles(10);
    cycle(1, 0, 0, 0, 1, 1);

    cycle(1, 1, 4, 5, 0, 0);
    cycle(1, 0, 0, 0, 1, 0);
    idle_cycles(2);
    cycle(1, 0, 0, 0, 0, 1);
    idle_cycles(20);
    cycle(1, 0, 0, 0, 0, 1);
    idle_cycles(3);

    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 1, 12, 10, 0, 0);
    cycle(1, 0, 0, 0, 1, 0);
    idle_cycles(3);
    cycle(1, 1, 1, 1, 0, 0);
    cycle(1, 1, 1, 1, 1, 0);
    idle_cycles(6);
    cycle(1, 1, 3, 7, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 3, 9, 0, 0);
    cycle(1, 0, 0, 0, 1, 0);
    idle_cycles(8);
    cycle(1, 0, 0, 0, 0, 1);
    idle_cycles(2);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0);
    idle_cycles(3);
    cycle(1, 0, 0, 0, 1, 1);
    cycle(1, 1, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 1, 0);
    idle_cycles(6);

    for (int i = 0; i < 4000; i++) begin
      bit rst_n, ld, st, pa;
      int lt, lo;
      rst_n = ($urandom_range(0, 299) != 0);
      ld    = ($urandom_range(0, 39) == 0);
      st    = ($urandom_range(0, 7) == 0);
      pa    = ($urandom_range(0, 19) == 0);
      lt    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1));
      lo    = int'($urandom_range(0, 15));
      cycle(rst_n, ld, lt, lo, st, pa);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
